melody_sequencer: RTL
=====================

Name: melody_sequencer

Overview:
- Plays a fixed 8-note melody by stepping through an internal note ROM.
- Drives the 12-bit note frequency consumed by the tone generator and by the 7-segment note display.
- Times each note in beat ticks derived from the system clock, with a silent gap between notes.
- Supports start, stop and loop control from board buttons/switches, already debounced upstream.

Parameters:
- TICK_DIV, 6250000: clock cycles per beat tick (1/16 s at 100 MHz). Must be even and ≥2.
- GAP_TICKS, 1: silent ticks inserted after every note. 0 means no gap.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- play  input  1  single-cycle start pulse
- stop  input  1  single-cycle stop pulse
- loop  input  1  level; 1 means restart at note 0 after the last note
- tempo_fast  input  1  level; used only with SEQ_TEMPO_EN, otherwise ignored
- freq  output  12  current note frequency in Hz; 0 = silence
- note_idx  output  3  index of the current or last-played note
- busy  output  1  high while the sequence is active
- done  output  1  one-cycle pulse when the sequence ends without looping

Behaviour:
- Note ROM, fixed, indexed 0..7:
  - Frequencies: 262, 294, 330, 349, 392, 440, 494, 523.
  - Durations in ticks: 2, 2, 2, 2, 2, 2, 2, 4.
- Reset (async, rst_n=0):
  - state=IDLE; freq=0, note_idx=0, busy=0, done=0.
  - Tick counter and duration counter cleared.
- All outputs are registered.
- Tick counter:
  - Counts 0..TICK_DIV-1; a tick fires on the wrap cycle.
  - Cleared on play acceptance, so the first note lasts exactly D*TICK_DIV cycles.
- States:
  - IDLE: freq=0, busy=0. On play=1 (and stop=0) → NOTE with idx=0. freq=ROM[0] and busy=1 from the next cycle (1-cycle latency).
  - NOTE: freq=ROM[idx]. The duration counter is loaded with dur[idx] on entry and decremented on each tick. The tick that takes it to 0 → GAP, or directly to the next-note decision if GAP_TICKS=0.
  - GAP: freq=0, busy=1, for GAP_TICKS*TICK_DIV cycles. At the end:
    - idx<7 → NOTE with idx+1.
    - idx==7 and loop=1 → NOTE with idx=0.
    - idx==7 and loop=0 → IDLE, done=1 for one cycle (same cycle busy falls).
- note_idx tracks idx and holds its last value in IDLE; it is reset to 0 only by stop or reset.
- loop is sampled only at the end-of-song decision.
- stop has highest priority, in any state:
  - Next cycle: IDLE, freq=0, busy=0, note_idx=0, counters cleared.
  - No done pulse.
- play while busy=1 is ignored (no restart).
- play and stop in the same cycle: stop wins.
- Timing: each note occupies exactly dur*TICK_DIV cycles; each gap occupies exactly GAP_TICKS*TICK_DIV cycles.

Optional Feature:
- SEQ_TEMPO_EN defined:
  - Tick terminal count = (tempo_fast ? TICK_DIV/2 : TICK_DIV) - 1.
  - Compare is "counter ≥ terminal", so a mid-count switch to fast with the counter past the new limit wraps on the next cycle.
- SEQ_TEMPO_EN undefined:
  - tempo_fast is ignored; the divisor is always TICK_DIV.
  - No tempo logic is synthesised; the port remains present.

Test Plan (TICK_DIV=4, GAP_TICKS=1 unless noted):
- Reset, then hold rst_n=0 mid-note → freq=0, note_idx=0, busy=0, done=0 immediately (asynchronously).
- play pulse at cycle n → freq=262, busy=1 in cycles n+1..n+8; freq=0 in n+9..n+12; freq=294 at n+13.
- Full song, loop=0 → notes 262..523 in order, 523 held 16 cycles; done high exactly once, 104 cycles after play acceptance; then busy=0, freq=0, note_idx=7.
- loop=1 → after 523 and its gap, freq=262 with note_idx=0; done never asserts; clearing loop before the next end lets the sequence end normally.
- stop during note 3 (freq=349) → next cycle freq=0, busy=0, note_idx=0, no done. A later play restarts at 262. play and stop in the same IDLE cycle → stays IDLE. play pulses while busy → no effect on sequence timing.
- With SEQ_TEMPO_EN, tempo_fast=1 → 262 held 4 cycles, gap 2 cycles. Without the macro, the same stimulus → 262 held 8 cycles.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a fixed 8-note ROM and emits note frequency, index and status.
// Optional SEQ_TEMPO_EN: tempo_fast halves the beat tick period.
module melody_sequencer #(
    parameter int TICK_DIV  = 6250000,
    parameter int GAP_TICKS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        stop,
    input  logic        loop,
    input  logic        tempo_fast,
    output logic [11:0] freq,
    output logic [2:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = 8;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [DW-1:0]   dur_q, dur_d;
    logic [2:0]      idx_q, idx_d;
    logic [11:0]     freq_q, freq_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick, adv;

    function automatic logic [11:0] rom_freq(input logic [2:0] i);
        case (i)
            3'd0: rom_freq = 12'd262;
            3'd1: rom_freq = 12'd294;
            3'd2: rom_freq = 12'd330;
            3'd3: rom_freq = 12'd349;
            3'd4: rom_freq = 12'd392;
            3'd5: rom_freq = 12'd440;
            3'd6: rom_freq = 12'd494;
            default: rom_freq = 12'd523;
        endcase
    endfunction

    function automatic logic [DW-1:0] rom_dur(input logic [2:0] i);
        rom_dur = (i == 3'd7) ? DW'(4) : DW'(2);
    endfunction

`ifdef SEQ_TEMPO_EN
    // >= compare so a mid-count switch to fast wraps on the next cycle
    logic [TW-1:0] term;
    assign term = tempo_fast ? TW'(TICK_DIV/2 - 1) : TW'(TICK_DIV - 1);
    assign tick = (tick_q >= term);
`else
    logic unused_tempo;
    assign unused_tempo = tempo_fast;
    assign tick = (tick_q == TW'(TICK_DIV - 1));
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        tick_d  = tick ? '0 : tick_q + 1'b1;
        done_d  = 1'b0;
        adv     = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (play) begin
                    state_d = NOTE;
                    idx_d   = 3'd0;
                    dur_d   = rom_dur(3'd0);
                end
            end
            NOTE: begin
                if (tick) begin
                    if (dur_q == DW'(1)) begin
                        if (GAP_TICKS != 0) begin
                            state_d = GAP;
                            dur_d   = DW'(GAP_TICKS);
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q - 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (dur_q == DW'(1)) adv = 1'b1;
                    else                 dur_d = dur_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // end of note+gap: next note, wrap on loop, or finish
        if (adv) begin
            if (idx_q != 3'd7) begin
                state_d = NOTE;
                idx_d   = idx_q + 1'b1;
                dur_d   = rom_dur(idx_q + 1'b1);
            end else if (loop) begin
                state_d = NOTE;
                idx_d   = 3'd0;
                dur_d   = rom_dur(3'd0);
            end else begin
                state_d = IDLE;
                dur_d   = '0;
                done_d  = 1'b1;
            end
        end

        if (stop) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            dur_d   = '0;
            tick_d  = '0;
            done_d  = 1'b0;
        end

        freq_d = (state_d == NOTE) ? rom_freq(idx_d) : 12'd0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dur_q   <= '0;
            idx_q   <= 3'd0;
            freq_q  <= 12'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign freq     = freq_q;
    assign note_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
